// File: rtl/baby_pkg.sv
// Shared Baby store constants, ASCII codes and the snapshot dumper state type.
package baby_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_LINES = 32;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND_BIT, SEND_LF, FIN} dump_state_t;

  function automatic logic [7:0] bit2ascii(input logic b);
    return b ? ASCII_1 : ASCII_0;
  endfunction

endpackage

// File: rtl/store_snapshot_dumper_if.sv
// Control, store read port and byte TX stream of the snapshot dumper.
interface store_snapshot_dumper_if #(
  parameter int WORD_W = baby_pkg::WORD_W,
  parameter int ADDR_W = 5
) ();
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  start, abort, mem_rdata, tx_ready,
    output busy, done, mem_rd_en, mem_addr, tx_data, tx_valid
  );

  modport slave (
    output start, abort, mem_rdata, tx_ready,
    input  busy, done, mem_rd_en, mem_addr, tx_data, tx_valid
  );
endinterface

// File: rtl/store_snapshot_dumper.sv
// Reads the Baby store line by line and streams it as ASCII '0'/'1' chars,
// LSB first, with an LF after each line.
module store_snapshot_dumper #(
  parameter int WORD_W    = baby_pkg::WORD_W,
  parameter int NUM_LINES = baby_pkg::NUM_LINES,
  parameter int ADDR_W    = $clog2(NUM_LINES)
) (
  input  logic                    clk,
  input  logic                    reset,
  store_snapshot_dumper_if.master bus
);
  import baby_pkg::*;

  localparam int                IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(NUM_LINES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_W - 1);

  dump_state_t       state_q;
  logic [ADDR_W-1:0] line_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] shift_q;
  logic              abort_pend_q;
  logic              busy_q, done_q, rd_en_q, tx_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        tx_data_q;

  logic accept, abort_now, to_idle;

  assign accept    = tx_valid_q && bus.tx_ready;
  assign abort_now = bus.abort || abort_pend_q;

  // Abort only takes effect on a byte boundary: before the first byte of a
  // line, or once the byte on the wire has been accepted.
  always_comb begin
    to_idle = 1'b0;
    case (state_q)
      IDLE:              to_idle = 1'b0;
      READ, WAIT:        to_idle = abort_now;
      SEND_BIT, SEND_LF: to_idle = accept && abort_now;
      default:           to_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      line_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      abort_pend_q <= abort_pend_q | bus.abort;
      if (to_idle) begin
        state_q      <= IDLE;
        busy_q       <= 1'b0;
        tx_valid_q   <= 1'b0;
        abort_pend_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            abort_pend_q <= 1'b0;
            if (bus.start) begin
              state_q <= READ;
              line_q  <= '0;
              addr_q  <= '0;
              rd_en_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          READ: state_q <= WAIT;
          WAIT: begin
            // Word is frozen here so later store writes cannot tear the line.
            shift_q    <= bus.mem_rdata;
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= bit2ascii(bus.mem_rdata[0]);
            state_q    <= SEND_BIT;
          end
          SEND_BIT: if (accept) begin
            if (idx_q == LAST_IDX) begin
              tx_data_q <= ASCII_LF;
              state_q   <= SEND_LF;
            end else begin
              shift_q   <= shift_q >> 1;
              idx_q     <= idx_q + 1'b1;
              tx_data_q <= bit2ascii(shift_q[1]);
            end
          end
          SEND_LF: if (accept) begin
            tx_valid_q <= 1'b0;
            if (line_q == LAST_LINE) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              line_q  <= line_q + 1'b1;
              addr_q  <= line_q + 1'b1;
              rd_en_q <= 1'b1;
              state_q <= READ;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;

endmodule

// File: tb/tb_store_snapshot_dumper.sv
// Directed + randomized bench for store_snapshot_dumper against a byte-stream model.
module tb_store_snapshot_dumper;
  import baby_pkg::*;

  localparam int PERIOD = 10;
  localparam int W      = WORD_W;
  localparam int LINES  = NUM_LINES;
  localparam int LBYTES = W + 1;
  localparam int BYTES  = LINES * LBYTES;

  logic clk = 1'b0;
  logic reset;
  always #(PERIOD/2) clk = ~clk;

  store_snapshot_dumper_if #(.WORD_W(W), .ADDR_W(5)) bus ();
  store_snapshot_dumper #(.WORD_W(W), .NUM_LINES(LINES), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [W-1:0] store [LINES];
  byte unsigned got[$];
  byte unsigned ref1[$];
  int     total = 0, bad = 0;
  int     done_cnt = 0, done_cyc = -1, stall_err = 0;
  longint t_start = 0;
  logic   prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Synchronous store read port plus byte/done/stall monitor.
  always @(posedge clk) bus.mem_rdata <= store[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    if (bus.done) begin
      done_cnt++;
      done_cyc = int'(($time - t_start) / PERIOD);
    end
    if (prev_stall && !(bus.tx_valid && bus.tx_data == prev_data)) stall_err++;
    prev_stall = bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
  end

  // Expected byte n of a full dump: line n/(W+1), char position n%(W+1).
  function automatic logic [7:0] exp_byte(input int n);
    int ln, pos;
    ln  = n / LBYTES;
    pos = n % LBYTES;
    if (pos == W) return ASCII_LF;
    return (((store[ln] >> pos) & 1) != 0) ? ASCII_1 : ASCII_0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_stream(input string tag);
    int mism = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_byte(i)) mism++;
    chk({tag, "_len"}, got.size(), BYTES);
    chk({tag, "_bytes"}, mism, 0);
  endtask

  task automatic chk_line(input string tag, input int ln, input string s);
    int mism = 0;
    if (got.size() < (ln + 1) * LBYTES) mism = 999;
    else begin
      for (int k = 0; k < W; k++) if (got[ln*LBYTES + k] !== s[k]) mism++;
      if (got[ln*LBYTES + W] !== ASCII_LF) mism++;
    end
    chk(tag, mism, 0);
  endtask

  task automatic start_dump(input bit with_abort);
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = with_abort;
    got.delete();
    done_cnt = 0;
    done_cyc = -1;
    @(posedge clk);
    t_start = $time;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
      n++;
    end
    bus.tx_ready = 1'b1;
    chk("idle_within_budget", n < budget, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bytes(input int cnt);
    int n = 0;
    while (got.size() < cnt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_byte_count", got.size(), cnt);
  endtask

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string line1, ones, l0;
    int target, mism;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < LINES; i++) store[i] = W'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    reset = 1'b0;
    bus.tx_ready = 1'b1;

    // Test 1: program image, sink always ready.
    line1 = "10011011111000101111110000111111";
    ones = "";
    for (int k = 0; k < W; k++) ones = {ones, "1"};
    for (int k = 0; k < W; k++) store[1][k] = (line1[k] == "1");
    store[27] = '1;
    start_dump(0);
    wait_idle(3000, 0);
    chk_stream("t1");
    chk_line("t1_line1", 1, line1);
    chk_line("t1_line27", 27, ones);
    chk("t1_done_cyc", done_cyc, 1121);
    chk("t1_done_cnt", done_cnt, 1);
    ref1 = got;

    // Test 2: random back-pressure must not change the stream.
    stall_err = 0;
    start_dump(0);
    wait_idle(6000, 1);
    mism = 0;
    for (int i = 0; i < got.size() && i < ref1.size(); i++) if (got[i] !== ref1[i]) mism++;
    chk("t2_len", got.size(), ref1.size());
    chk("t2_same_as_t1", mism, 0);
    chk("t2_stall_hold", stall_err, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // Test 3: start while busy is ignored.
    start_dump(0);
    wait_bytes(10 * LBYTES);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(3000, 0);
    chk_stream("t3");
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_done_cyc", done_cyc, 1121);

    // Test 4: abort while char 5 of line 3 is stalled.
    target = 3 * LBYTES + 5;
    start_dump(0);
    wait_bytes(target);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t4_stall_valid", bus.tx_valid, 1);
    chk("t4_stall_data", bus.tx_data, exp_byte(target));
    chk("t4_stall_busy", bus.busy, 1);
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_busy_after", bus.busy, 0);
    chk("t4_valid_after", bus.tx_valid, 0);
    repeat (100) @(negedge clk);
    chk("t4_nbytes", got.size(), target + 1);
    if (got.size() > target) chk("t4_last_byte", got[target], exp_byte(target));
    chk("t4_done_cnt", done_cnt, 0);

    // Test 5: asynchronous reset mid-line 20, then a fresh dump.
    start_dump(0);
    wait_bytes(20 * LBYTES + 10);
    #2 reset = 1'b1;
    #1;
    chk("t5_valid_async", bus.tx_valid, 0);
    chk("t5_busy_async", bus.busy, 0);
    chk("t5_rd_en_async", bus.mem_rd_en, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start_dump(0);
    wait_idle(3000, 0);
    chk_stream("t5");
    chk("t5_done_cyc", done_cyc, 1121);

    // Test 6: LSB-first order; abort in IDLE and abort with start are dropped.
    for (int i = 0; i < LINES; i++) store[i] = '0;
    store[0] = W'(1);
    l0 = "1";
    for (int k = 1; k < W; k++) l0 = {l0, "0"};
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    start_dump(1);
    wait_idle(3000, 0);
    chk_line("t6_line0", 0, l0);
    chk_stream("t6");
    chk("t6_done_cnt", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
